// File: rtl/seq_multiplier_16_pkg.sv
// ---------------------------------------------------------------------------
// seq_multiplier_16_pkg
// Shared definitions for the 16-bit sequential shift-add multiplier.
//   DATA_W      : datapath operand width (product is 2*DATA_W bits)
//   MUL_CNT_W   : iteration counter width, 2**MUL_CNT_W >= DATA_W
//   mul_state_e : multiplier control states (2-bit encoding)
// ---------------------------------------------------------------------------
package seq_multiplier_16_pkg;

  localparam int DATA_W    = 16;
  localparam int MUL_CNT_W = 4;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_RUN  = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

  // Number of iterations a multiply takes for a given operand width.
  function automatic int mul_steps(input int width);
    return width;
  endfunction

endpackage

// File: rtl/seq_multiplier_16_mult_step.sv
// ---------------------------------------------------------------------------
// seq_multiplier_16_mult_step
// One combinational shift-add iteration of the multiplier.
//   p      in  2*WIDTH  current partial-product / multiplier register
//   a      in  WIDTH    captured multiplicand
//   p_next out 2*WIDTH  register value after this iteration
// The upper half of p is added to a with a ripple of full-adder cells,
// keeping the carry-out so that the WIDTH+1-bit sum is never truncated.
// If p[0] is set the sum (with carry) replaces the upper half before the
// right shift; otherwise p is simply shifted right by one.
// ---------------------------------------------------------------------------
module seq_multiplier_16_mult_step #(
  parameter int WIDTH = 16
) (
  input  logic [2*WIDTH-1:0] p,
  input  logic [WIDTH-1:0]   a,
  output logic [2*WIDTH-1:0] p_next
);

  logic [WIDTH-1:0] sum;
  logic             carry_out;

  // Ripple-carry chain of full-adder cells: s = x^y^c, co = x&y | c&(x^y).
  always_comb begin
    logic c;
    logic x;
    logic y;
    c   = 1'b0;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      x      = p[WIDTH+i];
      y      = a[i];
      sum[i] = x ^ y ^ c;
      c      = (x & y) | (c & (x ^ y));
    end
    carry_out = c;
  end

  always_comb begin
    if (p[0]) begin
      p_next = {carry_out, sum, p[WIDTH-1:1]};
    end else begin
      p_next = {1'b0, p[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/seq_multiplier_16.sv
// ---------------------------------------------------------------------------
// seq_multiplier_16
// Multi-cycle unsigned shift-add multiplier (MULT/MULTU datapath block).
//   clk           in   1      system clock, rising edge
//   reset         in   1      synchronous active-high reset
//   start         in   1      multiply request, accepted in IDLE or DONE
//   multiplicand  in   WIDTH  operand A, captured on accepted start
//   multiplier    in   WIDTH  operand B, captured on accepted start
//   product_lo    out  WIDTH  low half of A*B
//   product_hi    out  WIDTH  high half of A*B
//   busy          out  1      iteration sequence in progress
//   done          out  1      one-cycle pulse, product valid
//
// state    | meaning
// ---------+-----------------------------------------------------------
// MUL_IDLE | waiting for start; outputs hold the previous product
// MUL_RUN  | one shift-add step per edge, WIDTH steps in total
// MUL_DONE | product valid for one cycle; start here restarts directly
//
// Start accepted at edge k: busy from k, done in the cycle after edge
// k+WIDTH, one result every WIDTH+1 cycles when started back to back.
// Products are driven straight from the P register, so they change while
// a run is in progress and hold the last result through IDLE.
// CNT_W must satisfy 2**CNT_W >= WIDTH.
// ---------------------------------------------------------------------------
module seq_multiplier_16
  import seq_multiplier_16_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(mul_steps(WIDTH) - 1);

  mul_state_e         state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_reg;
  logic [2*WIDTH-1:0] p_reg;
  logic [2*WIDTH-1:0] p_next;

  seq_multiplier_16_mult_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .p      (p_reg),
    .a      (a_reg),
    .p_next (p_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MUL_IDLE;
      cnt   <= '0;
      a_reg <= '0;
      p_reg <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        // DONE behaves like IDLE for start acceptance, which gives
        // back-to-back operation without an idle bubble.
        MUL_IDLE, MUL_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= multiplicand;
            p_reg <= {{WIDTH{1'b0}}, multiplier};
            cnt   <= '0;
            state <= MUL_RUN;
            busy  <= 1'b1;
          end else begin
            state <= MUL_IDLE;
            busy  <= 1'b0;
          end
        end

        // start is deliberately not looked at here.
        MUL_RUN: begin
          p_reg <= p_next;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_STEP) begin
            state <= MUL_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        default: begin
          state <= MUL_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign product_hi = p_reg[2*WIDTH-1:WIDTH];
  assign product_lo = p_reg[WIDTH-1:0];

endmodule

// File: tb/tb_seq_multiplier_16.sv
module tb_seq_multiplier_16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic [15:0] product_lo;
  logic [15:0] product_hi;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  seq_multiplier_16 dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product_lo   (product_lo),
    .product_hi   (product_hi),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive start for one edge and record the expected product.
  task automatic launch(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    exp_q.push_back(exp);
    step();
    start = 1'b0;
    check_val({name, "_busy_on_accept"}, 32'(busy), 32'd1);
    check_val({name, "_done_low_on_accept"}, 32'(done), 32'd0);
  endtask

  // n0 = edges already elapsed since the accepting edge.
  task automatic wait_done(input string name, input int n0);
    int          n;
    bit          seen;
    logic [31:0] exp;
    n    = n0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      step();
      n++;
      check_val({name, "_busy_done_exclusive"}, 32'(busy & done), 32'd0);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no done after %0d cycles, expected at 16", name, n);
      if (exp_q.size() != 0) exp = exp_q.pop_front();
    end else begin
      check_val({name, "_latency"}, 32'(n), 32'd16);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_scoreboard: got done, expected empty queue to hold a result", name);
      end else begin
        exp = exp_q.pop_front();
        check_val({name, "_product"}, {product_hi, product_lo}, exp);
      end
    end
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    int          gap;
    int          done_cnt;

    vecs[0] = '{16'h0003, 16'h0005, 32'h0000_000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vecs[2] = '{16'h0000, 16'h1234, 32'h0000_0000};
    vecs[3] = '{16'h00FF, 16'h0101, 32'h0000_FFFF};
    vecs[4] = '{16'h8000, 16'h0002, 32'h0001_0000};
    vecs[5] = '{16'h1234, 16'h0000, 32'h0000_0000};
    vecs[6] = '{16'h0001, 16'hFFFF, 32'h0000_FFFF};
    vecs[7] = '{16'h1234, 16'h5678, 32'h0626_0060};

    reset        = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    step();
    step();
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_done", 32'(done), 32'd0);
    check_val("reset_product", {product_hi, product_lo}, 32'd0);
    reset = 1'b0;
    step();

    // Table-driven vectors, each with a full idle gap afterwards.
    for (int i = 0; i < 8; i++) begin
      launch($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);
      wait_done($sformatf("vec%0d", i), 0);
      step();
      check_val($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
      check_val($sformatf("vec%0d_hold", i), {product_hi, product_lo}, vecs[i].exp);
    end

    // Reset in the middle of a run: at step 7 the run is aborted.
    launch("abort", 16'h1234, 16'h5678, 32'h0626_0060);
    repeat (6) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    check_val("abort_product", {product_hi, product_lo}, 32'd0);
    done_cnt = 0;
    repeat (25) begin
      step();
      if (done) done_cnt++;
    end
    check_val("abort_no_done", 32'(done_cnt), 32'd0);

    // start re-pulsed mid-run with new operands must be ignored.
    launch("ignore", 16'h00FF, 16'h0101, 32'h0000_FFFF);
    repeat (3) step();
    multiplicand = 16'h1234;
    multiplier   = 16'h5678;
    start        = 1'b1;
    step();
    start = 1'b0;
    wait_done("ignore", 4);

    // Back to back: start raised during DONE goes straight to RUN.
    multiplicand = 16'h8000;
    multiplier   = 16'h0002;
    start        = 1'b1;
    exp_q.push_back(32'h0001_0000);
    step();
    check_val("b2b_busy", 32'(busy), 32'd1);
    check_val("b2b_done_pulse", 32'(done), 32'd0);
    step();
    start = 1'b0;
    wait_done("b2b", 1);
    step();
    check_val("b2b_done_after", 32'(done), 32'd0);

    // Random pairs with random idle gaps.
    for (int i = 0; i < 1000; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      gap = int'($urandom_range(0, 3));
      launch("rand", ra, rb, 32'(ra) * 32'(rb));
      wait_done("rand", 0);
      for (int g = 0; g < gap; g++) begin
        step();
        check_val("rand_idle_done", 32'(done), 32'd0);
      end
    end
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
